tt_um_digiota_ctrl: RTL and testbench
=====================================

TT_UM_DIGIOTA_CTRL -- requirements
Module: tt_um_digiota_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for the SPI pins (legal values 2-3).
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  tile enable; ignored by all logic.
REQ-005 SHALL have port ui_in  input  8  dedicated inputs: [0] SCK, [1] MOSI, [2] CS_N, [7:3] unused.
REQ-006 SHALL have port uo_out  output  8  drives REG0.
REQ-007 SHALL have port uio_in  input  8  unused.
REQ-008 SHALL have port uio_out  output  8  [0] MISO; [7:1] drive REG1[7:1].
REQ-009 SHALL have port uio_oe  output  8  [0] constant 1; [7:1] drive REG2[7:1].

Function
REQ-010 SHALL act as an SPI mode-0 target: sample MOSI on SCK rising edges, change MISO on SCK falling edges, MSB first.
REQ-011 SHALL pass SCK, MOSI and CS_N through SYNC_STAGES flip-flops before any use; SCK edges detected from the last two synchronized samples.
REQ-012 SHALL support SCK frequencies up to clk/8; faster SCK is out of scope.
REQ-013 SHALL frame 16 bits: bit15 = W (1 write, 0 read), bits14:8 = address, bits7:0 = data.
REQ-014 SHALL hold registers REG0-REG2 (read/write, 8 bit) and REG3 (read-only write counter); addresses 4-127 invalid.
REQ-015 SHALL implement FSM states IDLE, CMD, DATA, DONE.
REQ-016 IDLE -> CMD on synchronized CS_N falling edge; CMD -> DATA after 8th SCK rising edge; DATA -> DONE after 16th SCK rising edge; any state -> IDLE on synchronized CS_N high.
REQ-017 In DONE, further SCK edges SHALL be ignored until CS_N rises.
REQ-018 On write to a valid address, the register SHALL update exactly on the clk cycle in which DATA -> DONE occurs.
REQ-019 A write to an invalid address or to address 3 SHALL change no register and SHALL NOT increment REG3.
REQ-020 REG3 SHALL increment by 1 on each committed write to addresses 0-2, wrapping 255 -> 0.
REQ-021 On read, the addressed register SHALL be captured at the CMD -> DATA transition; bit7 SHALL appear on MISO at the next SCK falling edge, then one bit per falling edge.
REQ-022 Read of an invalid address SHALL return 0x00.
REQ-023 MISO SHALL be 0 whenever not in DATA of a read frame.
REQ-024 CS_N rising before the 16th SCK rising edge SHALL abort: no register change, REG3 unchanged.
REQ-025 CS_N rising in the same clk cycle as the 16th SCK rising edge detection SHALL abort the frame (CS_N takes priority).
REQ-026 uio_out[7:1] and uio_oe[7:1] SHALL reflect REG1/REG2 bits 7:1; bit 0 of REG1/REG2 SHALL be stored and readable but SHALL NOT drive pins.

Reset
REQ-027 rst_n low SHALL immediately force: FSM IDLE, REG0-REG3 = 0x00, uo_out = 0x00, uio_out = 0x00, uio_oe = 0x01, synchronizers cleared (CS_N synchronizer to 1).
REQ-028 Reset asserted mid-frame SHALL discard the frame; after release the target SHALL ignore SCK until a fresh CS_N falling edge.

Verification
REQ-029 Write frame 0x80A5 (W, addr 0, data 0xA5) -> uo_out = 0xA5 on the cycle DATA -> DONE, REG3 = 0x01.
REQ-030 Write 0x82FE then read frame 0x0200 -> uio_oe = 0xFF, MISO bits 7:0 = 0xFE.
REQ-031 CS_N raised after 12 SCK edges of frame 0x803C -> uo_out unchanged, REG3 unchanged.
REQ-032 256 writes to address 1, then read address 3 -> MISO returns 0x00 (wrap); write to address 0x05 -> no register changes.
REQ-033 rst_n pulsed low during DATA of a write -> all outputs at reset values, subsequent SCK edges without new CS_N fall ignored.
REQ-034 Read of address 0x40 -> MISO = 0x00 across all 8 data bits; 20 SCK edges in one frame -> only first 16 used.

Source files
------------

// File: rtl/tt_um_digiota_ctrl.sv
// -----------------------------------------------------------------------------
// tt_um_digiota_ctrl
//   SPI mode-0 target giving access to four 8-bit registers:
//     REG0..REG2 read/write, REG3 read-only count of committed writes.
//   Frame (MSB first, 16 bits): [15] W (1 write / 0 read), [14:8] address,
//   [7:0] data. Addresses 4..127 are invalid (reads return 0x00).
//
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   ena      tile enable (ignored)
//   ui_in    [0] SCK, [1] MOSI, [2] CS_N, [7:3] unused
//   uo_out   REG0
//   uio_in   unused
//   uio_out  [0] MISO, [7:1] REG1[7:1]
//   uio_oe   [0] constant 1, [7:1] REG2[7:1]
// -----------------------------------------------------------------------------
module tt_um_digiota_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

   localparam logic [1:0] FLUSH_N = 2'(SYNC_STAGES);

   // Pins that exist on the tile but carry no function here.
   logic unused_ok;
   assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

   // ---------------------------------------------------------------------------
   // Input synchronizers and edge detection
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, csn_sync_q;
   logic                   sck_prev_q, csn_prev_q;
   logic [1:0]             flush_cnt_q;
   logic                   armed_q;
   logic                   sck_s, mosi_s, csn_s;
   logic                   sck_rise, sck_fall, cs_fall;

   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign csn_s  = csn_sync_q[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   // A CS_N fall only counts once CS_N has really been seen high after reset,
   // so a chip select held low across reset cannot reopen the aborted frame.
   assign cs_fall  = armed_q & csn_prev_q & ~csn_s;

   // NOTE: every flop here is updated with <= so all registers sample the
   // pre-edge values; blocking assignments would collapse the shift chains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         csn_sync_q  <= '1;
         sck_prev_q  <= 1'b0;
         csn_prev_q  <= 1'b1;
         flush_cnt_q <= '0;
         armed_q     <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  ui_in[0]};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], ui_in[1]};
         csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0],  ui_in[2]};
         sck_prev_q  <= sck_s;
         csn_prev_q  <= csn_s;
         // Wait until the reset values have left the chain before trusting CS_N.
         if (flush_cnt_q != FLUSH_N) flush_cnt_q <= flush_cnt_q + 2'd1;
         if (flush_cnt_q == FLUSH_N && csn_s) armed_q <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Frame FSM and register file
   // ---------------------------------------------------------------------------
   state_t     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       wr_q, wr_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] rd_sr_q, rd_sr_d;
   logic       miso_q, miso_d;
   logic [7:0] reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d, wcnt_q, wcnt_d;
   logic [7:0] data_byte, rd_mux;

   // Byte completed by the current rising edge: seven earlier bits plus MOSI.
   assign data_byte = {shift_q, mosi_s};

   always_comb begin
      unique case (data_byte[6:0])
         7'd0:    rd_mux = reg0_q;
         7'd1:    rd_mux = reg1_q;
         7'd2:    rd_mux = reg2_q;
         7'd3:    rd_mux = wcnt_q;
         default: rd_mux = 8'h00;
      endcase
   end

   // NOTE: each _d gets its current value first, so every path through the
   // case assigns it and no latch can be inferred.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      rd_sr_d   = rd_sr_q;
      miso_d    = miso_q;
      reg0_d    = reg0_q;
      reg1_d    = reg1_q;
      reg2_d    = reg2_q;
      wcnt_d    = wcnt_q;

      unique case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d   = CMD;
               bit_cnt_d = '0;
            end
         end
         CMD: begin
            if (csn_s) begin
               state_d = IDLE;
            end else if (sck_rise) begin
               shift_d   = data_byte[6:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd7) begin
                  state_d = DATA;
                  wr_d    = data_byte[7];
                  addr_d  = data_byte[6:0];
                  rd_sr_d = rd_mux;
                  miso_d  = 1'b0;
               end
            end
         end
         DATA: begin
            // CS_N is checked first: it wins over a coincident 16th edge.
            if (csn_s) begin
               state_d = IDLE;
            end else if (sck_fall && !wr_q) begin
               miso_d  = rd_sr_q[7];
               rd_sr_d = {rd_sr_q[6:0], 1'b0};
            end else if (sck_rise) begin
               shift_d   = data_byte[6:0];
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd15) begin
                  state_d = DONE;
                  if (wr_q) begin
                     unique case (addr_q)
                        7'd0:    begin reg0_d = data_byte; wcnt_d = wcnt_q + 8'd1; end
                        7'd1:    begin reg1_d = data_byte; wcnt_d = wcnt_q + 8'd1; end
                        7'd2:    begin reg2_d = data_byte; wcnt_d = wcnt_q + 8'd1; end
                        default: ;
                     endcase
                  end
               end
            end
         end
         DONE: begin
            if (csn_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the four user registers are plain flops, so all of them are reset;
   // there is no RAM here that would have to be left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         rd_sr_q   <= '0;
         miso_q    <= 1'b0;
         reg0_q    <= '0;
         reg1_q    <= '0;
         reg2_q    <= '0;
         wcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         rd_sr_q   <= rd_sr_d;
         miso_q    <= miso_d;
         reg0_q    <= reg0_d;
         reg1_q    <= reg1_d;
         reg2_q    <= reg2_d;
         wcnt_q    <= wcnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   logic miso;
   assign miso    = miso_q & (state_q == DATA) & ~wr_q;
   assign uo_out  = reg0_q;
   assign uio_out = {reg1_q[7:1], miso};
   assign uio_oe  = {reg2_q[7:1], 1'b1};

endmodule

// File: tb/tb_tt_um_digiota_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tt_um_digiota_ctrl
//   Drives SPI frames into tt_um_digiota_ctrl (SCK = clk/8) and compares
//   MISO data and pin outputs against a table of expected values, a few
//   hand-written corner sequences and a register-array reference model.
// -----------------------------------------------------------------------------
module tb_tt_um_digiota_ctrl;

   localparam int SYNC = 2;
   localparam int HALF = 4;   // SCK half period in clk cycles

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = 8'h04;  // CS_N high, SCK low
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out, uio_out, uio_oe;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the four registers as the SPI master sees them.
   logic [7:0] mdl [4];

   tt_um_digiota_ctrl #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cs_low();
      ui_in[2] = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic cs_high();
      wait_clks(HALF);
      ui_in[2] = 1'b1;
      wait_clks(HALF + 2);
   endtask

   // One SCK period; MISO is sampled just before the rising edge, as a
   // mode-0 master would.
   task automatic send_bit(input logic b, output logic m);
      ui_in[1] = b;
      wait_clks(HALF);
      m = uio_out[0];
      ui_in[0] = 1'b1;
      wait_clks(HALF);
      ui_in[0] = 1'b0;
   endtask

   task automatic do_frame(input logic [15:0] w, input int nbits, output logic [7:0] rd);
      logic m;
      rd = 8'h00;
      cs_low();
      for (int i = 0; i < nbits; i++) begin
         send_bit((i < 16) ? w[15-i] : 1'b0, m);
         if (i >= 8 && i < 16) rd[15-i] = m;
      end
      cs_high();
   endtask

   task automatic check_pins(input string tag, input logic [7:0] e_uo,
                             input logic [7:0] e_uio, input logic [7:0] e_oe);
      check({tag, " uo_out"},  uo_out,  e_uo);
      check({tag, " uio_out"}, uio_out, e_uio);
      check({tag, " uio_oe"},  uio_oe,  e_oe);
   endtask

   typedef struct {
      logic [15:0] word;
      int          nbits;
      logic [7:0]  exp_miso;
      logic [7:0]  exp_uo;
      logic [7:0]  exp_uio;
      logic [7:0]  exp_oe;
   } vec_t;

   vec_t vecs [15];

   initial begin
      logic [7:0] rd;
      logic       m;
      int         k;
      string      nm;

      vecs[0]  = '{16'h80A5, 16, 8'h00, 8'hA5, 8'h00, 8'h01};  // write REG0
      vecs[1]  = '{16'h0300, 16, 8'h01, 8'hA5, 8'h00, 8'h01};  // count = 1
      vecs[2]  = '{16'h82FE, 16, 8'h00, 8'hA5, 8'h00, 8'hFF};  // write REG2
      vecs[3]  = '{16'h0200, 16, 8'hFE, 8'hA5, 8'h00, 8'hFF};  // read REG2
      vecs[4]  = '{16'h803C, 12, 8'h00, 8'hA5, 8'h00, 8'hFF};  // aborted write
      vecs[5]  = '{16'h0300, 16, 8'h02, 8'hA5, 8'h00, 8'hFF};  // abort not counted
      vecs[6]  = '{16'h8155, 16, 8'h00, 8'hA5, 8'h54, 8'hFF};  // REG1 bit0 off pins
      vecs[7]  = '{16'h0100, 16, 8'h55, 8'hA5, 8'h54, 8'hFF};  // bit0 readable
      vecs[8]  = '{16'h8577, 16, 8'h00, 8'hA5, 8'h54, 8'hFF};  // invalid address
      vecs[9]  = '{16'h8377, 16, 8'h00, 8'hA5, 8'h54, 8'hFF};  // REG3 read-only
      vecs[10] = '{16'h0300, 16, 8'h03, 8'hA5, 8'h54, 8'hFF};
      vecs[11] = '{16'h4000, 16, 8'h00, 8'hA5, 8'h54, 8'hFF};  // invalid read
      vecs[12] = '{16'h0000, 20, 8'hA5, 8'hA5, 8'h54, 8'hFF};  // over-long read
      vecs[13] = '{16'h80C3, 20, 8'h00, 8'hC3, 8'h54, 8'hFF};  // over-long write
      vecs[14] = '{16'h0300, 16, 8'h04, 8'hC3, 8'h54, 8'hFF};

      // Reset state, checked while reset is still asserted.
      wait_clks(2);
      check_pins("reset", 8'h00, 8'h00, 8'h01);
      wait_clks(1);
      rst_n = 1'b1;
      wait_clks(6);
      check_pins("after reset", 8'h00, 8'h00, 8'h01);

      // Table-driven frames.
      foreach (vecs[i]) begin
         do_frame(vecs[i].word, vecs[i].nbits, rd);
         nm = $sformatf("vec%0d", i);
         check({nm, " miso"}, rd, vecs[i].exp_miso);
         check_pins(nm, vecs[i].exp_uo, vecs[i].exp_uio, vecs[i].exp_oe);
      end

      // CS_N rising together with the 16th SCK rise aborts the write.
      cs_low();
      for (int i = 0; i < 15; i++) send_bit(((16'h8011 >> (15 - i)) & 16'h1) != 0, m);
      ui_in[1] = 1'b1;
      wait_clks(HALF);
      ui_in[0] = 1'b1;
      ui_in[2] = 1'b1;
      wait_clks(HALF);
      ui_in[0] = 1'b0;
      wait_clks(HALF + 2);
      check("cs priority uo_out", uo_out, 8'hC3);
      do_frame(16'h0300, 16, rd);
      check("cs priority count", rd, 8'h04);

      // Write commit lands SYNC+1 clk edges after the 16th SCK rise.
      cs_low();
      for (int i = 0; i < 15; i++) send_bit(((16'h805A >> (15 - i)) & 16'h1) != 0, m);
      ui_in[1] = 1'b0;
      wait_clks(HALF);
      ui_in[0] = 1'b1;
      k = 0;
      for (int c = 1; c <= 10; c++) begin
         wait_clks(1);
         if (k == 0 && uo_out == 8'h5A) k = c;
      end
      check("commit latency", 8'(k), 8'(SYNC + 1));
      ui_in[0] = 1'b0;
      cs_high();
      check("commit value", uo_out, 8'h5A);

      // Reset in the DATA phase of a write, then SCK activity without a new
      // CS_N fall must be ignored.
      cs_low();
      for (int i = 0; i < 10; i++) send_bit(((16'h8011 >> (15 - i)) & 16'h1) != 0, m);
      rst_n = 1'b0;
      #2;
      check_pins("mid-frame reset", 8'h00, 8'h00, 8'h01);
      wait_clks(3);
      rst_n = 1'b1;
      wait_clks(4);
      for (int i = 0; i < 16; i++) send_bit(((16'h8099 >> (15 - i)) & 16'h1) != 0, m);
      cs_high();
      check_pins("post-reset ignore", 8'h00, 8'h00, 8'h01);
      do_frame(16'h0300, 16, rd);
      check("post-reset count", rd, 8'h00);

      // 256 writes to REG1 wrap the write counter back to zero.
      for (int i = 0; i < 256; i++) do_frame({8'h81, 8'(i)}, 16, rd);
      do_frame(16'h0300, 16, rd);
      check("wrap count", rd, 8'h00);
      check("wrap uio_out", uio_out, 8'hFE);
      do_frame(16'h8577, 16, rd);
      do_frame(16'h0300, 16, rd);
      check("invalid write count", rd, 8'h00);
      check_pins("invalid write", 8'h00, 8'hFE, 8'h01);

      // Randomized frames against the register model.
      mdl[0] = 8'h00; mdl[1] = 8'hFF; mdl[2] = 8'h00; mdl[3] = 8'h00;
      for (int n = 0; n < 48; n++) begin
         logic       w;
         logic [6:0] a;
         logic [7:0] d, exp_rd;
         int         kind, nb;
         w    = 1'($urandom_range(0, 1));
         a    = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5));
         d    = 8'($urandom);
         kind = $urandom_range(0, 9);
         nb   = (kind == 7) ? 20 : (kind == 8) ? $urandom_range(1, 15) : 16;
         exp_rd = 8'h00;
         if (!w) exp_rd = (a < 7'd4) ? mdl[a[1:0]] : 8'h00;
         do_frame({w, a, d}, nb, rd);
         if (nb >= 16 && w && a < 7'd3) begin
            mdl[a[1:0]] = d;
            mdl[3]      = mdl[3] + 8'd1;
         end
         nm = $sformatf("rand%0d", n);
         if (nb >= 16 || w) check({nm, " miso"}, rd, exp_rd);
         check_pins(nm, mdl[0], {mdl[1][7:1], 1'b0}, {mdl[2][7:1], 1'b1});
      end
      do_frame(16'h0300, 16, rd);
      check("rand final count", rd, mdl[3]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
